// File: rtl/rsa_crt_decrypt.sv
// RSA CRT decryptor: m = c^d mod (p*q) via two concurrent H-bit exponentiations + Garner recombination.
// Latency: fixed H+3 edges from acceptance to out_valid (1 edge on the p<2 / q<2 error path).
// Backpressure: single request in flight; in_ready only in IDLE, result held in DONE until out_ready.
// Ports: clk/rst (async active-low); in_valid/in_ready + ciphertext,p,q,dp,dq,qinv request;
//        out_valid/out_ready + plaintext,error result (error qualified by out_valid).
module rsa_crt_decrypt #(
  parameter int W = 32,
  parameter int H = W / 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] ciphertext,
  input  logic [H-1:0] p,
  input  logic [H-1:0] q,
  input  logic [H-1:0] dp,
  input  logic [H-1:0] dq,
  input  logic [H-1:0] qinv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] plaintext,
  output logic         error
);

  localparam int CW = (H > 1) ? $clog2(H) : 1;
  localparam logic [CW-1:0] LAST = CW'(H - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REDUCE,
    S_EXP,
    S_COMB1,
    S_COMB2,
    S_DONE
  } state_t;

  state_t        r_state;
  logic [W-1:0]  r_c;
  logic [H-1:0]  r_p, r_q, r_qinv;
  logic [H-1:0]  r_bp, r_bq, r_rp, r_rq, r_ep, r_eq;
  logic [H-1:0]  r_h;
  logic [CW-1:0] r_cnt;

  // (a*b) mod m with a full 2H-bit product.
  function automatic logic [H-1:0] mulmod(input logic [H-1:0] a, input logic [H-1:0] b,
                                          input logic [H-1:0] m);
    logic [2*H-1:0] prod;
    prod = {{H{1'b0}}, a} * {{H{1'b0}}, b};
    return H'(prod % {{H{1'b0}}, m});
  endfunction

  // Divisors forced nonzero so the always-evaluated reductions never divide by zero;
  // the substituted value only occurs on the error path where results are discarded.
  logic [H-1:0] w_pd, w_qd;
  assign w_pd = (r_p == '0) ? H'(1) : r_p;
  assign w_qd = (r_q == '0) ? H'(1) : r_q;

  logic [H-1:0] w_bp_init, w_bq_init;
  assign w_bp_init = H'(r_c % {{(W-H){1'b0}}, w_pd});
  assign w_bq_init = H'(r_c % {{(W-H){1'b0}}, w_qd});

  logic [H-1:0] w_rp_nxt, w_rq_nxt, w_bp_nxt, w_bq_nxt;
  assign w_rp_nxt = r_ep[0] ? mulmod(r_rp, r_bp, w_pd) : r_rp;
  assign w_rq_nxt = r_eq[0] ? mulmod(r_rq, r_bq, w_qd) : r_rq;
  assign w_bp_nxt = mulmod(r_bp, r_bp, w_pd);
  assign w_bq_nxt = mulmod(r_bq, r_bq, w_qd);

  // Garner: h = qinv * (rp - rq) mod p, with the subtraction kept non-negative.
  logic [H-1:0] w_m2p, w_diff_h, w_h;
  logic [H:0]   w_diff;
  assign w_m2p    = r_rq % w_pd;
  assign w_diff   = (r_rp >= w_m2p) ? ({1'b0, r_rp} - {1'b0, w_m2p})
                                    : ({1'b0, r_rp} + {1'b0, r_p} - {1'b0, w_m2p});
  assign w_diff_h = H'(w_diff);  // diff < p, so the carry bit is always zero here
  assign w_h      = mulmod(r_qinv, w_diff_h, w_pd);

  logic [W-1:0] w_result;
  assign w_result = {{(W-H){1'b0}}, r_rq} + ({{(W-H){1'b0}}, r_h} * {{(W-H){1'b0}}, r_q});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      plaintext <= '0;
      error     <= 1'b0;
      r_c       <= '0;
      r_p       <= '0;
      r_q       <= '0;
      r_qinv    <= '0;
      r_bp      <= '0;
      r_bq      <= '0;
      r_rp      <= '0;
      r_rq      <= '0;
      r_ep      <= '0;
      r_eq      <= '0;
      r_h       <= '0;
      r_cnt     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_c      <= ciphertext;
            r_p      <= p;
            r_q      <= q;
            r_ep     <= dp;
            r_eq     <= dq;
            r_qinv   <= qinv;
            in_ready <= 1'b0;
            r_state  <= S_REDUCE;
          end
        end
        S_REDUCE: begin
          if (r_p < H'(2) || r_q < H'(2)) begin
            error     <= 1'b1;
            plaintext <= '0;
            out_valid <= 1'b1;
            r_state   <= S_DONE;
          end else begin
            r_bp    <= w_bp_init;
            r_bq    <= w_bq_init;
            r_rp    <= H'(1);
            r_rq    <= H'(1);
            r_cnt   <= '0;
            r_state <= S_EXP;
          end
        end
        S_EXP: begin
          // All H bits are processed regardless of exponent value: constant time.
          r_rp  <= w_rp_nxt;
          r_rq  <= w_rq_nxt;
          r_bp  <= w_bp_nxt;
          r_bq  <= w_bq_nxt;
          r_ep  <= r_ep >> 1;
          r_eq  <= r_eq >> 1;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == LAST) r_state <= S_COMB1;
        end
        S_COMB1: begin
          r_h     <= w_h;
          r_state <= S_COMB2;
        end
        S_COMB2: begin
          plaintext <= w_result;
          error     <= 1'b0;
          out_valid <= 1'b1;
          r_state   <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            error     <= 1'b0;
            in_ready  <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
